oam_dma: RTL and testbench

Sprite-DMA engine on the CPU's external bus, directly downstream of the 6502 core. It snoops CPU writes to $4014 and then stalls the CPU. It copies the 256-byte page $PP00–$PPFF to OAMDATA ($2004) as alternating read/write bus cycles. Its `stall` output feeds the CPU `stall` input, and its `dma_active` output is the bus-mux select between CPU and DMA address/control/data.

---
 rtl/oam_dma_pkg.sv | 22 ++
 rtl/oam_dma.sv | 116 +++++++++++
 tb/tb_oam_dma.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared constants for the sprite-DMA engine: bus addresses and the
// DMA_STATE encoding used by the controller FSM.
package oam_dma_pkg;

    // CPU write to this address starts a transfer (PPU OAMDMA register).
    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    // Every copied byte is written to this address (PPU OAMDATA register).
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    // DMA_STATE: plain encoded constants so legacy tools can share them.
    typedef logic [2:0] dma_state_t;

    localparam dma_state_t IDLE  = 3'd0;
    localparam dma_state_t HALT  = 3'd1;
    localparam dma_state_t ALIGN = 3'd2;
    localparam dma_state_t READ  = 3'd3;
    localparam dma_state_t WRITE = 3'd4;

    // Last byte index of a 256-byte page; the transfer ends after its write.
    localparam logic [7:0] LAST_IDX = 8'hFF;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA engine. Snoops CPU writes to TRIGGER_ADDR, stalls the CPU and
// copies page $PP00-$PPFF to TARGET_ADDR as alternating read/write cycles.
// dma_active is the select for the external CPU/DMA bus mux.
//
// Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when the
// HALT cycle falls on an odd CPU cycle (514 stall cycles instead of 513).
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_ADDR,
    parameter logic [15:0] TARGET_ADDR  = OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  rd_data,
    output logic        stall,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_read,
    output logic        dma_write,
    output logic [7:0]  dma_wdata,
    output logic [9:0]  busy_cycles
);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic        odd;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_q;
    logic        trigger;

    // A trigger is only acted on in IDLE; elsewhere it is simply ignored.
    assign trigger = cpu_write && (cpu_addr == TRIGGER_ADDR);

    // Free-running CPU cycle parity, kept in every build for observability.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) odd <= 1'b0;
        else     odd <= ~odd;
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt (no latch).
        state_nxt = state;
        case (state)
            IDLE:  if (trigger) state_nxt = HALT;
`ifdef OAM_DMA_ALIGN_EN
            HALT:  state_nxt = odd ? ALIGN : READ;
            ALIGN: state_nxt = READ;
`else
            HALT:  state_nxt = READ;
`endif
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = (idx == LAST_IDX) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transfer immediately with no resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Transfer datapath: page/index latch, read-data buffer, stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page        <= 8'h00;
            idx         <= 8'h00;
            data_q      <= 8'h00;
            busy_cycles <= 10'd0;
        end else begin
            if (state == IDLE) begin
                if (trigger) begin
                    page        <= cpu_wdata;
                    idx         <= 8'h00;
                    busy_cycles <= 10'd0;
                end
            end else begin
                busy_cycles <= busy_cycles + 10'd1;
            end
            if (state == READ) data_q <= rd_data;
            // idx stays 8 bits: page $FF ends at $FFFF, never carries into page.
            if (state == WRITE && idx != LAST_IDX) idx <= idx + 8'd1;
        end
    end

    // Bus outputs decoded from state; HALT/ALIGN own the bus but drive nothing.
    always_comb begin
        dma_active = (state != IDLE);
        stall      = dma_active;
        dma_addr   = 16'h0000;
        dma_read   = 1'b0;
        dma_write  = 1'b0;
        dma_wdata  = 8'h00;
        case (state)
            READ: begin
                dma_addr = {page, idx};
                dma_read = 1'b1;
            end
            WRITE: begin
                dma_addr  = TARGET_ADDR;
                dma_write = 1'b1;
                dma_wdata = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma. A behavioural model derives the expected
// bus activity of every stall cycle from the transfer rules (HALT, optional
// ALIGN, then 256 read/write pairs) and the cycle parity since reset.
module tb_oam_dma;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] OAMD = 16'h2004;

`ifdef OAM_DMA_ALIGN_EN
    localparam int ALIGN_EN = 1;
`else
    localparam int ALIGN_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  rd_data;
    logic        stall;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_read;
    logic        dma_write;
    logic [7:0]  dma_wdata;
    logic [9:0]  busy_cycles;

    int checks = 0;
    int errors = 0;
    int edges;
    int last_len = 0;

    oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .rd_data    (rd_data),
        .stall      (stall),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_read   (dma_read),
        .dma_write  (dma_write),
        .dma_wdata  (dma_wdata),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    // Memory model: read data is the low address byte XOR 8'h5A; idle bus is 8'hC3.
    assign rd_data = dma_read ? (dma_addr[7:0] ^ 8'h5A) : 8'hC3;

    // Clock cycles since reset release; its parity is the expected odd flag.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {stall,dma_active,dma_read,dma_write,dma_addr,wdata} in cycle c after the trigger edge.
    function automatic logic [31:0] model_vec(input int c, input int al, input int len,
                                              input logic [7:0] pg);
        int k;
        logic [7:0] n;
        if (c >= len) return 32'h0;
        if (c <= al) return {4'b0, 4'b1100, 16'h0000, 8'h00};
        k = c - 1 - al;
        n = 8'(k / 2);
        if (k % 2 == 0) return {4'b0, 4'b1110, pg, n, 8'h00};
        return {4'b0, 4'b1101, OAMD, n ^ 8'h5A};
    endfunction

    function automatic logic [31:0] obs_vec(input logic show_wdata);
        return {4'b0, stall, dma_active, dma_read, dma_write, dma_addr,
                show_wdata ? dma_wdata : 8'h00};
    endfunction

    // Wait (if needed) so that the HALT cycle after the next trigger has parity p.
    task automatic set_parity(input int p);
        if (((edges + 1) & 1) != p) @(negedge clk);
    endtask

    // Trigger at the next edge and check every cycle; abort_at >= 0 returns early.
    task automatic run_transfer(input logic [7:0] pg, input int abort_at);
        int al;
        int len;
        int k;
        logic wmask;
        cpu_addr  = TRIG;
        cpu_write = 1'b1;
        cpu_wdata = pg;
        al  = ALIGN_EN * ((edges + 1) & 1);
        len = 513 + al;
        @(posedge clk);
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            k = c - 1 - al;
            wmask = (c > al) && (c < len) && (k % 2 == 1);
            check($sformatf("cycle%0d_page%02h", c, pg), obs_vec(wmask), model_vec(c, al, len, pg));
            if (c == abort_at) begin
                cpu_write = 1'b0;
                return;
            end
            // Stray CPU writes, including to the trigger address, must be ignored while busy.
            if (c < len) begin
                cpu_write = 1'($urandom_range(0, 1));
                cpu_addr  = ($urandom_range(0, 1) == 1) ? TRIG : 16'($urandom);
                cpu_wdata = 8'($urandom);
            end else begin
                cpu_write = 1'b0;
                cpu_addr  = 16'($urandom);
            end
        end
        check($sformatf("busy_page%02h", pg), 32'(busy_cycles), 32'(len));
        last_len = len;
    endtask

    initial begin
        int al;
        rst       = 1'b1;
        cpu_addr  = 16'h0000;
        cpu_write = 1'b0;
        cpu_wdata = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs_vec(1'b1), 32'h0);
        check("reset_busy", 32'(busy_cycles), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", obs_vec(1'b1), 32'h0);

        // Even-start transfer of page $02.
        set_parity(0);
        run_transfer(8'h02, -1);

        // Odd-start transfer of page $02 (ALIGN inserted only when enabled).
        set_parity(1);
        run_transfer(8'h02, -1);

        // Page wrap: last read is $FFFF, index never carries into the page.
        set_parity(int'($urandom_range(0, 1)));
        run_transfer(8'hFF, -1);

        // Non-trigger CPU activity leaves the engine idle.
        cpu_write = 1'b1; cpu_addr = 16'h4015; cpu_wdata = 8'($urandom);
        @(negedge clk);
        check("write_4015_idle", obs_vec(1'b1), 32'h0);
        cpu_addr = 16'h2004;
        @(negedge clk);
        check("write_2004_idle", obs_vec(1'b1), 32'h0);
        cpu_write = 1'b0; cpu_addr = TRIG;
        @(negedge clk);
        check("read_4014_idle", obs_vec(1'b1), 32'h0);
        cpu_addr = 16'h0000;
        @(negedge clk);
        check("idle_still", obs_vec(1'b1), 32'h0);
        check("busy_holds_idle", 32'(busy_cycles), 32'(last_len));

        // Reset in the WRITE cycle of byte 100: outputs drop before any clock edge.
        set_parity(0);
        al = ALIGN_EN * ((edges + 1) & 1);
        run_transfer(8'h40, 1 + al + 201);
        #2 rst = 1'b1;
        #1;
        check("async_reset_drop", obs_vec(1'b1), 32'h0);
        @(negedge clk);
        check("reset_busy_clear", 32'(busy_cycles), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_abort", obs_vec(1'b1), 32'h0);
        run_transfer(8'h03, -1);

        // Random pages, some triggered in the very first IDLE cycle.
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_transfer(8'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
